special_reg_bank: RTL and testbench
===================================

// Module: special_reg_bank
// PURPOSE
//  Holds the special registers SHA, SHB, PSW, CWP, TB, SWP and PC. Sits directly
//  downstream of the destination-address decoder and consumes its seven write
//  strobes plus the writeback data bus. Also maintains the register-window pointer
//  on call/return and raises window overflow/underflow trap pulses.
// PARAMETERS
//  DATA_W  32  width of wdata and of PSW/TB/PC
//  SH_W    5   width of SHA/SHB (shift amounts)
//  CWP_W   3   width of CWP/SWP; number of windows = 2**CWP_W (modulo wrap)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  reset        in   1       asynchronous, active-high reset
//  wdata        in   DATA_W  writeback data accompanying strobes
//  writetoSHA1  in   1       immediate write SHA <= wdata[SH_W-1:0]
//  writetoSHB1  in   1       immediate write SHB <= wdata[SH_W-1:0]
//  writetoPSW1  in   1       immediate write PSW <= wdata
//  writetoCWP1  in   1       immediate write CWP <= wdata[CWP_W-1:0]
//  pwritetoTB   in   1       pending (1-cycle delayed) write TB
//  pwritetoSWP  in   1       pending write SWP <= wdata[CWP_W-1:0]
//  pwritetoPC   in   1       pending write PC
//  call_i       in   1       call: CWP decrements
//  ret_i        in   1       return: CWP increments
//  pc_adv_i     in   1       sequential PC advance: PC <= pc_next_i
//  pc_next_i    in   DATA_W  next sequential PC
//  sha, shb     out  SH_W    register contents
//  psw, tb, pc  out  DATA_W  register contents
//  cwp, swp     out  CWP_W   register contents
//  win_ovf      out  1       1-cycle pulse: window overflow trap
//  win_unf      out  1       1-cycle pulse: window underflow trap
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-pending): all registers 0, pending slot empty,
//    win_ovf/win_unf 0. Outputs are registered values, no combinational paths.
//  - Immediate strobes (*1): target updated at the edge ending the strobe cycle;
//    visible on outputs next cycle. Strobes are independent; several at once all write.
//  - Pending strobes (pwriteto*): edge N captures {sel, wdata} into a one-entry
//    pending slot; edge N+1 commits to target. Visible 2 cycles after strobe.
//    New pending strobe while slot full: old entry commits, new entry captured, same
//    edge (back-to-back pending writes each land exactly 1 cycle after capture).
//    Multiple pending strobes in one cycle: all selected targets take the same data.
//  - PC per edge, priority: pending PC commit > pc_adv_i > hold.
//  - CWP per edge, priority: writetoCWP1 > (call_i xor ret_i) > hold.
//    call only: CWP <= CWP-1 mod 2**CWP_W; ret only: CWP <= CWP+1 mod 2**CWP_W;
//    call and ret together: no change, no trap.
//  - Traps, compared with pre-edge CWP/SWP (ignore same-edge SWP commit):
//    win_ovf=1 next cycle if call only and (CWP-1) mod 2**CWP_W == SWP;
//    win_unf=1 next cycle if ret only and CWP == SWP. CWP still moves on trap.
//    Suppressed when writetoCWP1 is asserted the same cycle.
//  - Wrap: CWP 0 -call-> max value; max value -ret-> 0.
// TESTING
//  - reset mid-pending: pwritetoTB wdata=0xDEAD, reset next cycle -> tb stays 0.
//  - writetoPSW1 wdata=0x1234 cycle 0 -> psw=0x1234 cycle 1; pwritetoPC wdata=0x40
//    with pc_adv_i=1 pc_next_i=0x8 at commit edge -> pc=0x40 (commit wins).
//  - back-to-back pending: pwritetoTB 0x11 cyc0, pwritetoSWP 0x5 cyc1 -> tb=0x11
//    from cyc2, swp=5 from cyc3.
//  - CWP wrap: from reset (cwp=0, swp=0) set swp=2; call -> cwp=7; ret,ret -> 0,1;
//    no traps.
//  - traps: cwp=3, swp=2, call -> cwp=2, win_ovf pulse 1 cycle; cwp=2, swp=2,
//    ret -> cwp=3, win_unf pulse; call+ret same cycle -> cwp unchanged, no pulse.
//  - writetoCWP1 wdata=5 with call_i=1 -> cwp=5, no win_ovf.

Source files
------------

// File: rtl/special_reg_bank_if.sv
// special_reg_bank_if
//   Bundles the writeback side of the special register bank: the data bus,
//   the immediate and pending write strobes, the call/return/PC-advance
//   controls, and the register contents and trap pulses coming back.
//   Port summary:
//     wdata, writetoSHA1/SHB1/PSW1/CWP1, pwritetoTB/SWP/PC,
//     call_i, ret_i, pc_adv_i, pc_next_i        master -> slave
//     sha, shb, psw, tb, pc, cwp, swp,
//     win_ovf, win_unf                          slave -> master
//   The master modport belongs to the decoder/sequencer side; the slave
//   modport belongs to special_reg_bank.
interface special_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5,
    parameter int CWP_W  = 3
);
    logic [DATA_W-1:0] wdata;
    logic              writetoSHA1;
    logic              writetoSHB1;
    logic              writetoPSW1;
    logic              writetoCWP1;
    logic              pwritetoTB;
    logic              pwritetoSWP;
    logic              pwritetoPC;
    logic              call_i;
    logic              ret_i;
    logic              pc_adv_i;
    logic [DATA_W-1:0] pc_next_i;

    logic [SH_W-1:0]   sha;
    logic [SH_W-1:0]   shb;
    logic [DATA_W-1:0] psw;
    logic [DATA_W-1:0] tb;
    logic [DATA_W-1:0] pc;
    logic [CWP_W-1:0]  cwp;
    logic [CWP_W-1:0]  swp;
    logic              win_ovf;
    logic              win_unf;

    modport master (
        output wdata, writetoSHA1, writetoSHB1, writetoPSW1, writetoCWP1,
        output pwritetoTB, pwritetoSWP, pwritetoPC,
        output call_i, ret_i, pc_adv_i, pc_next_i,
        input  sha, shb, psw, tb, pc, cwp, swp, win_ovf, win_unf
    );

    modport slave (
        input  wdata, writetoSHA1, writetoSHB1, writetoPSW1, writetoCWP1,
        input  pwritetoTB, pwritetoSWP, pwritetoPC,
        input  call_i, ret_i, pc_adv_i, pc_next_i,
        output sha, shb, psw, tb, pc, cwp, swp, win_ovf, win_unf
    );
endinterface

// File: rtl/special_reg_bank.sv
// special_reg_bank
//   Special registers SHA, SHB, PSW, CWP, TB, SWP and PC, written from the
//   writeback bus under the destination decoder's strobes. SHA/SHB/PSW/CWP
//   are written immediately; TB/SWP/PC go through a one-entry pending slot
//   and land one edge after capture. CWP also moves on call (down) and
//   return (up) with modulo wrap, raising one-cycle window overflow and
//   underflow trap pulses.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    special_reg_bank_if.slave (strobes, data, register contents)
//   All outputs come straight from flops.
module special_reg_bank #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5,
    parameter int CWP_W  = 3
) (
    input logic              clk,
    input logic              reset,
    special_reg_bank_if.slave bus
);

    localparam int SEL_TB  = 0;
    localparam int SEL_SWP = 1;
    localparam int SEL_PC  = 2;

    localparam logic [CWP_W-1:0] CWP_ONE = CWP_W'(1);

    logic [SH_W-1:0]   sha_q;
    logic [SH_W-1:0]   shb_q;
    logic [DATA_W-1:0] psw_q;
    logic [DATA_W-1:0] tb_q;
    logic [DATA_W-1:0] pc_q;
    logic [CWP_W-1:0]  cwp_q;
    logic [CWP_W-1:0]  swp_q;
    logic              win_ovf_q;
    logic              win_unf_q;

    // One-entry pending slot; sel is one-hot-ish (several bits may be set
    // when several pending strobes arrive together, all sharing the data).
    logic              pend_valid_q;
    logic [2:0]        pend_sel_q;
    logic [DATA_W-1:0] pend_data_q;

    logic [2:0]        pend_sel_in;
    logic              call_only;
    logic              ret_only;
    logic [CWP_W-1:0]  cwp_dec;
    logic [CWP_W-1:0]  cwp_inc;
    logic              commit_tb;
    logic              commit_swp;
    logic              commit_pc;

    always_comb begin
        pend_sel_in          = 3'b000;
        pend_sel_in[SEL_TB]  = bus.pwritetoTB;
        pend_sel_in[SEL_SWP] = bus.pwritetoSWP;
        pend_sel_in[SEL_PC]  = bus.pwritetoPC;
    end

    assign call_only  = bus.call_i & ~bus.ret_i;
    assign ret_only   = bus.ret_i & ~bus.call_i;
    assign cwp_dec    = cwp_q - CWP_ONE;
    assign cwp_inc    = cwp_q + CWP_ONE;

    assign commit_tb  = pend_valid_q & pend_sel_q[SEL_TB];
    assign commit_swp = pend_valid_q & pend_sel_q[SEL_SWP];
    assign commit_pc  = pend_valid_q & pend_sel_q[SEL_PC];

    // Immediate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sha_q <= '0;
            shb_q <= '0;
            psw_q <= '0;
        end else begin
            if (bus.writetoSHA1) sha_q <= bus.wdata[SH_W-1:0];
            if (bus.writetoSHB1) shb_q <= bus.wdata[SH_W-1:0];
            if (bus.writetoPSW1) psw_q <= bus.wdata;
        end
    end

    // Pending slot: the old entry commits and a new one is captured on the
    // same edge, so back-to-back pending writes never stall or drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_sel_q   <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= |pend_sel_in;
            pend_sel_q   <= pend_sel_in;
            if (|pend_sel_in) pend_data_q <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_q  <= '0;
            swp_q <= '0;
        end else begin
            if (commit_tb)  tb_q  <= pend_data_q;
            if (commit_swp) swp_q <= pend_data_q[CWP_W-1:0];
        end
    end

    // A pending PC commit (a branch target) beats the sequential advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (commit_pc) begin
            pc_q <= pend_data_q;
        end else if (bus.pc_adv_i) begin
            pc_q <= bus.pc_next_i;
        end
    end

    // Window pointer; call and return together cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwp_q <= '0;
        end else if (bus.writetoCWP1) begin
            cwp_q <= bus.wdata[CWP_W-1:0];
        end else if (call_only) begin
            cwp_q <= cwp_dec;
        end else if (ret_only) begin
            cwp_q <= cwp_inc;
        end
    end

    // Traps use the pre-edge CWP/SWP; a direct CWP write in the same cycle
    // overrides the call/return and so raises no trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_ovf_q <= 1'b0;
            win_unf_q <= 1'b0;
        end else begin
            win_ovf_q <= ~bus.writetoCWP1 & call_only & (cwp_dec == swp_q);
            win_unf_q <= ~bus.writetoCWP1 & ret_only & (cwp_q == swp_q);
        end
    end

    assign bus.sha     = sha_q;
    assign bus.shb     = shb_q;
    assign bus.psw     = psw_q;
    assign bus.tb      = tb_q;
    assign bus.pc      = pc_q;
    assign bus.cwp     = cwp_q;
    assign bus.swp     = swp_q;
    assign bus.win_ovf = win_ovf_q;
    assign bus.win_unf = win_unf_q;

endmodule

// File: tb/tb_special_reg_bank.sv
// tb_special_reg_bank
//   Directed vectors with hand-computed expectations for special_reg_bank.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. they reflect the edge just taken.
module tb_special_reg_bank;
    localparam int DATA_W = 32;
    localparam int SH_W   = 5;
    localparam int CWP_W  = 3;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    special_reg_bank_if #(.DATA_W(DATA_W), .SH_W(SH_W), .CWP_W(CWP_W)) bus ();

    special_reg_bank #(.DATA_W(DATA_W), .SH_W(SH_W), .CWP_W(CWP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wdata       = '0;
        bus.writetoSHA1 = 1'b0;
        bus.writetoSHB1 = 1'b0;
        bus.writetoPSW1 = 1'b0;
        bus.writetoCWP1 = 1'b0;
        bus.pwritetoTB  = 1'b0;
        bus.pwritetoSWP = 1'b0;
        bus.pwritetoPC  = 1'b0;
        bus.call_i      = 1'b0;
        bus.ret_i       = 1'b0;
        bus.pc_adv_i    = 1'b0;
        bus.pc_next_i   = '0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clear_inputs();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        tick();

        check("rst_sha", 32'(bus.sha), 32'h0);
        check("rst_shb", 32'(bus.shb), 32'h0);
        check("rst_psw", bus.psw, 32'h0);
        check("rst_tb",  bus.tb,  32'h0);
        check("rst_pc",  bus.pc,  32'h0);
        check("rst_cwp", 32'(bus.cwp), 32'h0);
        check("rst_swp", 32'(bus.swp), 32'h0);
        check("rst_ovf", 32'(bus.win_ovf), 32'h0);
        check("rst_unf", 32'(bus.win_unf), 32'h0);

        // Reset while a TB write sits in the pending slot.
        bus.pwritetoTB = 1'b1;
        bus.wdata      = 32'hDEAD;
        tick();
        clear_inputs();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        check("rstpend_tb0", bus.tb, 32'h0);
        tick();
        check("rstpend_tb1", bus.tb, 32'h0);

        // Immediate PSW write.
        bus.writetoPSW1 = 1'b1;
        bus.wdata       = 32'h1234;
        tick();
        clear_inputs();
        check("psw_imm", bus.psw, 32'h1234);

        // SHA and SHB in the same cycle take the low shift bits.
        bus.writetoSHA1 = 1'b1;
        bus.writetoSHB1 = 1'b1;
        bus.wdata       = 32'h3F7;
        tick();
        clear_inputs();
        check("sha_imm", 32'(bus.sha), 32'h17);
        check("shb_imm", 32'(bus.shb), 32'h17);

        // Pending PC commit beats pc_adv_i.
        bus.pwritetoPC = 1'b1;
        bus.wdata      = 32'h40;
        tick();
        clear_inputs();
        check("pc_capture", bus.pc, 32'h0);
        bus.pc_adv_i  = 1'b1;
        bus.pc_next_i = 32'h8;
        tick();
        check("pc_commit_wins", bus.pc, 32'h40);
        bus.pc_next_i = 32'h44;
        tick();
        clear_inputs();
        check("pc_adv", bus.pc, 32'h44);

        // Back-to-back pending writes.
        bus.pwritetoTB = 1'b1;
        bus.wdata      = 32'h11;
        tick();
        clear_inputs();
        bus.pwritetoSWP = 1'b1;
        bus.wdata       = 32'h5;
        tick();
        clear_inputs();
        check("b2b_tb_cyc2", bus.tb, 32'h11);
        check("b2b_swp_cyc2", 32'(bus.swp), 32'h0);
        tick();
        check("b2b_swp_cyc3", 32'(bus.swp), 32'h5);
        check("b2b_tb_cyc3", bus.tb, 32'h11);

        // Two pending strobes at once share the data.
        bus.pwritetoTB = 1'b1;
        bus.pwritetoPC = 1'b1;
        bus.wdata      = 32'h77;
        tick();
        clear_inputs();
        tick();
        check("multi_tb", bus.tb, 32'h77);
        check("multi_pc", bus.pc, 32'h77);

        // CWP wrap with swp=2, cwp=0.
        bus.writetoCWP1 = 1'b1;
        bus.pwritetoSWP = 1'b1;
        bus.wdata       = 32'h2;
        tick();
        clear_inputs();
        bus.writetoCWP1 = 1'b1;
        bus.wdata       = 32'h0;
        tick();
        clear_inputs();
        check("wrap_setup_swp", 32'(bus.swp), 32'h2);
        check("wrap_setup_cwp", 32'(bus.cwp), 32'h0);
        bus.call_i = 1'b1;
        tick();
        clear_inputs();
        check("wrap_call_cwp", 32'(bus.cwp), 32'h7);
        check("wrap_call_ovf", 32'(bus.win_ovf), 32'h0);
        bus.ret_i = 1'b1;
        tick();
        check("wrap_ret1_cwp", 32'(bus.cwp), 32'h0);
        check("wrap_ret1_unf", 32'(bus.win_unf), 32'h0);
        tick();
        clear_inputs();
        check("wrap_ret2_cwp", 32'(bus.cwp), 32'h1);
        check("wrap_ret2_unf", 32'(bus.win_unf), 32'h0);

        // Overflow: cwp=3, swp=2, call.
        bus.writetoCWP1 = 1'b1;
        bus.wdata       = 32'h3;
        tick();
        clear_inputs();
        bus.call_i = 1'b1;
        tick();
        clear_inputs();
        check("ovf_cwp", 32'(bus.cwp), 32'h2);
        check("ovf_pulse", 32'(bus.win_ovf), 32'h1);
        check("ovf_no_unf", 32'(bus.win_unf), 32'h0);
        tick();
        check("ovf_pulse_end", 32'(bus.win_ovf), 32'h0);

        // Underflow: cwp=2, swp=2, ret.
        bus.ret_i = 1'b1;
        tick();
        clear_inputs();
        check("unf_cwp", 32'(bus.cwp), 32'h3);
        check("unf_pulse", 32'(bus.win_unf), 32'h1);
        tick();
        check("unf_pulse_end", 32'(bus.win_unf), 32'h0);

        // Call and return together: no movement, no trap (cwp=3, swp=2).
        bus.call_i = 1'b1;
        bus.ret_i  = 1'b1;
        tick();
        clear_inputs();
        check("callret_cwp", 32'(bus.cwp), 32'h3);
        check("callret_ovf", 32'(bus.win_ovf), 32'h0);
        check("callret_unf", 32'(bus.win_unf), 32'h0);

        // Direct CWP write overrides a trapping call (cwp=3, swp=2).
        bus.writetoCWP1 = 1'b1;
        bus.call_i      = 1'b1;
        bus.wdata       = 32'h5;
        tick();
        clear_inputs();
        check("cwpwr_cwp", 32'(bus.cwp), 32'h5);
        check("cwpwr_no_ovf", 32'(bus.win_ovf), 32'h0);

        // Simultaneous immediate strobes both write.
        bus.writetoPSW1 = 1'b1;
        bus.writetoCWP1 = 1'b1;
        bus.wdata       = 32'h6;
        tick();
        clear_inputs();
        check("multi_imm_psw", bus.psw, 32'h6);
        check("multi_imm_cwp", 32'(bus.cwp), 32'h6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end want end");
        $fatal(1, "timeout");
    end
endmodule
